// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: counts 100 Hz ticks as BCD SS.cc (00.00 .. MAX_SEC_TENS9.99),
// with a start/pause/lap/clear control FSM and a lap-freeze display register.
module stopwatch_bcd_counter #(
  parameter logic [3:0] MAX_SEC_TENS = 4'd5
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_cs_tens,
  output logic [3:0] disp_cs_ones,
  output logic       running,
  output logic       lap_active,
  output logic       wrap_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_LAP_RUN = 2'd3
  } state_t;

  // Returns {carry, next_digit}; any out-of-range digit is forced back to 0.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit);
    logic [4:0] result;
    if (digit >= 4'd9) begin
      result = {1'b1, 4'd0};
    end else begin
      result = {1'b0, digit + 4'd1};
    end
    return result;
  endfunction

  state_t     r_state;
  logic       r_tick_s1;
  logic       r_tick_s2;
  logic       r_start_prev;
  logic       r_lap_prev;
  logic       r_clear_prev;
  logic [3:0] r_sec_tens;
  logic [3:0] r_sec_ones;
  logic [3:0] r_cs_tens;
  logic [3:0] r_cs_ones;

  state_t     w_next_state;
  logic       w_tick_pulse;
  logic       w_start_press;
  logic       w_lap_press;
  logic       w_clear_press;
  logic       w_count_en;
  logic       w_clear_live;
  logic       w_hold_disp;
  logic [4:0] w_cs_ones_inc;
  logic [4:0] w_cs_tens_inc;
  logic [4:0] w_sec_ones_inc;
  logic       w_roll_cs_tens;
  logic       w_roll_sec_ones;
  logic       w_roll_sec_tens;
  logic       w_wrap;
  logic [3:0] w_next_sec_tens;
  logic [3:0] w_next_sec_ones;
  logic [3:0] w_next_cs_tens;
  logic [3:0] w_next_cs_ones;

  assign w_tick_pulse  = r_tick_s1 & ~r_tick_s2;
  assign w_start_press = btn_start & ~r_start_prev;
  assign w_lap_press   = btn_lap & ~r_lap_prev;
  assign w_clear_press = btn_clear & ~r_clear_prev;

  assign w_count_en = ((r_state == ST_RUN) || (r_state == ST_LAP_RUN)) && w_tick_pulse;

  assign w_cs_ones_inc  = bcd_digit_inc(r_cs_ones);
  assign w_cs_tens_inc  = bcd_digit_inc(r_cs_tens);
  assign w_sec_ones_inc = bcd_digit_inc(r_sec_ones);

  assign w_roll_cs_tens  = w_cs_ones_inc[4];
  assign w_roll_sec_ones = w_roll_cs_tens & w_cs_tens_inc[4];
  assign w_roll_sec_tens = w_roll_sec_ones & w_sec_ones_inc[4];
  assign w_wrap          = w_roll_sec_tens & (r_sec_tens >= MAX_SEC_TENS);

  // Incremented live count; the lower digits are already 0 whenever w_wrap is set.
  always_comb begin
    w_next_cs_ones = w_cs_ones_inc[3:0];
    if (w_roll_cs_tens) begin
      w_next_cs_tens = w_cs_tens_inc[3:0];
    end else begin
      w_next_cs_tens = r_cs_tens;
    end
    if (w_roll_sec_ones) begin
      w_next_sec_ones = w_sec_ones_inc[3:0];
    end else begin
      w_next_sec_ones = r_sec_ones;
    end
    if (w_wrap) begin
      w_next_sec_tens = 4'd0;
    end else if (w_roll_sec_tens) begin
      w_next_sec_tens = r_sec_tens + 4'd1;
    end else begin
      w_next_sec_tens = r_sec_tens;
    end
  end

  // Control transitions; priority clear > start > lap among presses the state honours.
  always_comb begin
    w_next_state = r_state;
    w_clear_live = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clear_press) begin
          w_next_state = ST_IDLE;
          w_clear_live = 1'b1;
        end else if (w_start_press) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_start_press) begin
          w_next_state = ST_PAUSE;
        end else if (w_lap_press) begin
          w_next_state = ST_LAP_RUN;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_LAP_RUN: begin
        if (w_start_press) begin
          w_next_state = ST_PAUSE;
        end else if (w_lap_press) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_LAP_RUN;
        end
      end
      ST_PAUSE: begin
        if (w_clear_press) begin
          w_next_state = ST_IDLE;
          w_clear_live = 1'b1;
        end else if (w_start_press) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_PAUSE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_clear_live = 1'b1;
      end
    endcase
  end

  assign w_hold_disp = (r_state == ST_LAP_RUN) && (w_next_state == ST_LAP_RUN);

  // Tick synchroniser and button edge-detect history; clear leaves these alone.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_tick_s1    <= 1'b0;
      r_tick_s2    <= 1'b0;
      r_start_prev <= 1'b0;
      r_lap_prev   <= 1'b0;
      r_clear_prev <= 1'b0;
    end else begin
      r_tick_s1    <= tick_in;
      r_tick_s2    <= r_tick_s1;
      r_start_prev <= btn_start;
      r_lap_prev   <= btn_lap;
      r_clear_prev <= btn_clear;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      running    <= (w_next_state == ST_RUN) || (w_next_state == ST_LAP_RUN);
      lap_active <= (w_next_state == ST_LAP_RUN);
      wrap_pulse <= w_count_en & w_wrap;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_cs_tens  <= 4'd0;
      r_cs_ones  <= 4'd0;
    end else if (w_clear_live) begin
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_cs_tens  <= 4'd0;
      r_cs_ones  <= 4'd0;
    end else if (w_count_en) begin
      r_sec_tens <= w_next_sec_tens;
      r_sec_ones <= w_next_sec_ones;
      r_cs_tens  <= w_next_cs_tens;
      r_cs_ones  <= w_next_cs_ones;
    end else begin
      r_sec_tens <= r_sec_tens;
      r_sec_ones <= r_sec_ones;
      r_cs_tens  <= r_cs_tens;
      r_cs_ones  <= r_cs_ones;
    end
  end

  // Display tracks the pre-increment live count, except while frozen inside LAP_RUN.
  always_ff @(posedge clk_in) begin
    if (rst || w_clear_live) begin
      disp_sec_tens <= 4'd0;
      disp_sec_ones <= 4'd0;
      disp_cs_tens  <= 4'd0;
      disp_cs_ones  <= 4'd0;
    end else if (w_hold_disp) begin
      disp_sec_tens <= disp_sec_tens;
      disp_sec_ones <= disp_sec_ones;
      disp_cs_tens  <= disp_cs_tens;
      disp_cs_ones  <= disp_cs_ones;
    end else begin
      disp_sec_tens <= r_sec_tens;
      disp_sec_ones <= r_sec_ones;
      disp_cs_tens  <= r_cs_tens;
      disp_cs_ones  <= r_cs_ones;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: linear steps, immediate-assertion checks.
module tb_stopwatch_bcd_counter;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] disp_sec_tens;
  logic [3:0] disp_sec_ones;
  logic [3:0] disp_cs_tens;
  logic [3:0] disp_cs_ones;
  logic       running;
  logic       lap_active;
  logic       wrap_pulse;

  int errors = 0;
  int checks = 0;
  int wrap_cnt = 0;
  int bad_digit = 0;

  stopwatch_bcd_counter #(.MAX_SEC_TENS(4'd5)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .disp_sec_tens(disp_sec_tens), .disp_sec_ones(disp_sec_ones),
    .disp_cs_tens(disp_cs_tens), .disp_cs_ones(disp_cs_ones),
    .running(running), .lap_active(lap_active), .wrap_pulse(wrap_pulse)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (wrap_pulse) wrap_cnt++;
    if (disp_sec_tens > 4'd9 || disp_sec_ones > 4'd9 ||
        disp_cs_tens > 4'd9 || disp_cs_ones > 4'd9) bad_digit++;
  end

  function automatic logic [15:0] disp_word();
    return {disp_sec_tens, disp_sec_ones, disp_cs_tens, disp_cs_ones};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Each tick: high two clocks, low two clocks; display is settled on return.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      cyc(2);
      tick_in = 1'b0;
      cyc(2);
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0; cyc(1);
  endtask

  task automatic press_lap();
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0; cyc(1);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; cyc(1); btn_clear = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
  endtask

  initial begin
    // Reset state
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("reset_disp", disp_word(), 16'h0000);
    check("reset_flags", {13'd0, running, lap_active, wrap_pulse}, 16'h0000);

    // Start and 150 ticks
    press_start();
    check("start_running", {15'd0, running}, 16'h0001);
    do_ticks(150);
    check("t150_disp", disp_word(), 16'h0150);
    check("t150_running", {15'd0, running}, 16'h0001);
    check("t150_nowrap", wrap_cnt[15:0], 16'd0);

    // Full range wrap
    do_reset();
    wrap_cnt = 0;
    press_start();
    do_ticks(5999);
    check("max_disp", disp_word(), 16'h5999);
    check("max_nowrap", wrap_cnt[15:0], 16'd0);
    do_ticks(1);
    check("wrap_disp", disp_word(), 16'h0000);
    check("wrap_once", wrap_cnt[15:0], 16'd1);
    check("no_bad_digit", bad_digit[15:0], 16'd0);

    // Lap freeze and release
    do_ticks(123);
    check("prelap_disp", disp_word(), 16'h0123);
    press_lap();
    check("lap_active_on", {15'd0, lap_active}, 16'h0001);
    do_ticks(100);
    check("lap_frozen", disp_word(), 16'h0123);
    check("lap_still_active", {14'd0, running, lap_active}, 16'h0003);
    btn_lap = 1'b1;
    cyc(1);
    check("lap_release_disp", disp_word(), 16'h0223);
    check("lap_release_flag", {15'd0, lap_active}, 16'h0000);
    btn_lap = 1'b0;
    cyc(1);

    // Pause, clear, clear ignored in RUN
    do_reset();
    press_start();
    do_ticks(42);
    press_start();
    check("pause_running", {15'd0, running}, 16'h0000);
    do_ticks(20);
    check("pause_hold", disp_word(), 16'h0042);
    press_clear();
    check("clear_disp", disp_word(), 16'h0000);
    check("clear_idle_flags", {14'd0, running, lap_active}, 16'h0000);
    do_ticks(3);
    check("idle_no_count", disp_word(), 16'h0000);
    press_start();
    do_ticks(5);
    press_clear();
    do_ticks(3);
    check("clear_in_run_ignored", disp_word(), 16'h0008);
    check("clear_in_run_running", {15'd0, running}, 16'h0001);

    // Simultaneous start+lap in RUN, then held start
    btn_start = 1'b1;
    btn_lap = 1'b1;
    cyc(1);
    check("start_lap_same", {14'd0, running, lap_active}, 16'h0000);
    btn_start = 1'b0;
    btn_lap = 1'b0;
    cyc(1);
    do_ticks(2);
    check("start_lap_paused", disp_word(), 16'h0008);
    btn_start = 1'b1;
    cyc(1000);
    check("held_start_one_toggle", {15'd0, running}, 16'h0001);
    btn_start = 1'b0;
    cyc(1);
    do_ticks(10);
    check("held_start_counting", disp_word(), 16'h0018);

    // Reset while in LAP_RUN at 37.05
    do_reset();
    press_start();
    do_ticks(3705);
    press_lap();
    check("pre_rst_lap", {12'd0, 2'd0, running, lap_active}, 16'h0003);
    check("pre_rst_disp", disp_word(), 16'h3705);
    wrap_cnt = 0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_lap_disp", disp_word(), 16'h0000);
    check("rst_lap_flags", {13'd0, running, lap_active, wrap_pulse}, 16'h0000);
    do_ticks(5);
    check("rst_no_count", disp_word(), 16'h0000);
    check("rst_idle", {15'd0, running}, 16'h0000);
    press_start();
    do_ticks(1);
    check("rst_then_start", disp_word(), 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
